// File: rtl/ddr_user_frontend_if.sv
// User command/write/read and controller request bundle for ddr_user_frontend.
// The master side is the user and controller environment; slave is the front end.
interface ddr_user_frontend_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_RW;
  logic [1:0]  CMD_BA;
  logic [12:0] CMD_ROW;
  logic [9:0]  CMD_COL;
  logic [3:0]  CMD_LEN;
  logic [15:0] WR_DATA;
  logic        WR_VALID;
  logic        WR_READY;
  logic [15:0] RD_DATA;
  logic        RD_VALID;
  logic        ERR;
  logic        WRITE;
  logic        READ;
  logic [1:0]  BA_IN;
  logic [12:0] ADDR_ROW_IN;
  logic [9:0]  ADDR_COL_IN;
  logic [3:0]  WRITE_LENGTH;
  logic        BUSY;
  logic        EXT_DQS;

  modport master (
    output CMD_VALID, CMD_RW, CMD_BA, CMD_ROW, CMD_COL, CMD_LEN,
    output WR_DATA, WR_VALID, BUSY, EXT_DQS,
    input  CMD_READY, WR_READY, RD_DATA, RD_VALID, ERR,
    input  WRITE, READ, BA_IN, ADDR_ROW_IN, ADDR_COL_IN, WRITE_LENGTH
  );

  modport slave (
    input  CMD_VALID, CMD_RW, CMD_BA, CMD_ROW, CMD_COL, CMD_LEN,
    input  WR_DATA, WR_VALID, BUSY, EXT_DQS,
    output CMD_READY, WR_READY, RD_DATA, RD_VALID, ERR,
    output WRITE, READ, BA_IN, ADDR_ROW_IN, ADDR_COL_IN, WRITE_LENGTH
  );
endinterface

// File: rtl/ddr_user_frontend.sv
// Front end for ddr_sdram: buffers write words, holds WRITE/READ until BUSY rises, then moves one word
// per EXT_DQS rise (2-cycle latency). Write commands stall until the FIFO holds the whole burst.
module ddr_user_frontend #(
  parameter int BURST_LENGTH = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int REQ_TIMEOUT  = 1024
) (
  input  logic               SYS_CLK_100M,
  input  logic               RST,
  ddr_user_frontend_if.slave bus,
  inout  wire  [15:0]        DATA_IN
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(REQ_TIMEOUT);
  localparam int SW = $clog2(BURST_LENGTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_busy_s, r_busy_p, r_dqs_s, r_dqs_p;
  logic          w_busy_rise, w_busy_fall, w_dqs_rise;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_rm;
  logic [15:0]   w_head;
  logic          w_push, w_pop, w_drop;
  logic [4:0]    r_pop_left;
  logic [SW-1:0] r_stb_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_is_wr, r_write, r_read, r_err, r_rd_vld;
  logic [15:0]   r_rd_data, r_dq_out;
  logic [1:0]    r_ba;
  logic [12:0]   r_row;
  logic [9:0]    r_col;
  logic [3:0]    r_wlen;
  logic          w_cmd_rdy, w_accept, w_timeout, w_dq_oe;

  // Sync register feeds the edge detectors; the history register gives the previous sample.
  assign w_busy_rise = r_busy_s & ~r_busy_p;
  assign w_busy_fall = ~r_busy_s & r_busy_p;
  assign w_dqs_rise  = r_dqs_s & ~r_dqs_p;

  assign w_push  = bus.WR_VALID && (r_count < CW'(FIFO_DEPTH));
  assign w_pop   = (r_state == S_XFER) && r_is_wr && w_dqs_rise && (r_pop_left != '0);
  assign w_drop  = (r_state == S_XFER) && r_is_wr && w_busy_fall;
  // On an early exit the remaining words of this command leave the FIFO in one step.
  assign w_rm    = w_drop ? CW'(r_pop_left) : CW'(w_pop);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_dq_oe = (r_state == S_XFER) && r_is_wr;
  assign w_accept = bus.CMD_VALID && w_cmd_rdy;

  always_ff @(posedge SYS_CLK_100M) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_rdy   = 1'b0;
    w_timeout   = (r_tmo == TW'(REQ_TIMEOUT - 1));
    case (r_state)
      S_IDLE: begin
        w_cmd_rdy = bus.CMD_RW ? (int'(r_count) > int'(bus.CMD_LEN)) : 1'b1;
        if (bus.CMD_VALID && w_cmd_rdy) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_busy_rise)    w_state_nxt = S_XFER;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_XFER: begin
        if (w_busy_fall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (RST) w_cmd_rdy = 1'b0;
  end

  always_ff @(posedge SYS_CLK_100M) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.WR_DATA;
  end

  always_ff @(posedge SYS_CLK_100M) begin
    if (RST) begin
      r_busy_s   <= 1'b0;
      r_busy_p   <= 1'b0;
      r_dqs_s    <= 1'b0;
      r_dqs_p    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pop_left <= '0;
      r_stb_cnt  <= '0;
      r_tmo      <= '0;
      r_is_wr    <= 1'b0;
      r_write    <= 1'b0;
      r_read     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rd_data  <= '0;
      r_dq_out   <= '0;
      r_ba       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_wlen     <= '0;
    end else begin
      r_busy_s <= bus.BUSY;
      r_busy_p <= r_busy_s;
      r_dqs_s  <= bus.EXT_DQS;
      r_dqs_p  <= r_dqs_s;
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_rm);
      r_count  <= r_count + CW'(w_push) - w_rm;
      r_rd_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ba       <= bus.CMD_BA;
            r_row      <= bus.CMD_ROW;
            r_col      <= bus.CMD_COL;
            r_wlen     <= bus.CMD_LEN;
            r_is_wr    <= bus.CMD_RW;
            r_write    <= bus.CMD_RW;
            r_read     <= !bus.CMD_RW;
            r_pop_left <= bus.CMD_RW ? ({1'b0, bus.CMD_LEN} + 5'd1) : 5'd0;
            r_stb_cnt  <= '0;
            r_tmo      <= '0;
            r_dq_out   <= '0;
          end
        end
        S_REQ: begin
          if (w_busy_rise) begin
            r_write <= 1'b0;
            r_read  <= 1'b0;
          end else if (w_timeout) begin
            r_write <= 1'b0;
            r_read  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_XFER: begin
          if (w_dqs_rise) begin
            if (r_stb_cnt < SW'(BURST_LENGTH)) r_stb_cnt <= r_stb_cnt + SW'(1);
            if (r_is_wr) begin
              // Strobes beyond the command length still clock a word out, as zeros.
              if (r_pop_left != '0) begin
                r_dq_out   <= w_head;
                r_pop_left <= r_pop_left - 5'd1;
              end else begin
                r_dq_out <= '0;
              end
            end else if (r_stb_cnt < SW'(BURST_LENGTH)) begin
              r_rd_data <= DATA_IN;
              r_rd_vld  <= 1'b1;
            end
          end
          if (w_busy_fall) r_pop_left <= '0;
        end
        default: ;
      endcase
    end
  end

  assign DATA_IN          = w_dq_oe ? r_dq_out : 16'hzzzz;
  assign bus.CMD_READY    = w_cmd_rdy;
  assign bus.WR_READY     = (r_count < CW'(FIFO_DEPTH));
  assign bus.RD_DATA      = r_rd_data;
  assign bus.RD_VALID     = r_rd_vld;
  assign bus.ERR          = r_err;
  assign bus.WRITE        = r_write;
  assign bus.READ         = r_read;
  assign bus.BA_IN        = r_ba;
  assign bus.ADDR_ROW_IN  = r_row;
  assign bus.ADDR_COL_IN  = r_col;
  assign bus.WRITE_LENGTH = r_wlen;
endmodule
